axi_llc_flush_walker: RTL and testbench



---
 rtl/axi_llc_flush_walker.sv | 166 ++++++++++++++++
 tb/tb_axi_llc_flush_walker.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_llc_flush_walker.sv
// Walks every (way, index) of the selected LLC ways, asks the tag store to flush each
// line and forwards dirty lines as write-back descriptors. Optional macro: AXI_LLC_FLUSH_STATS_EN.
module axi_llc_flush_walker #(
    parameter int unsigned SetAssociativity = 8,
    parameter int unsigned NumLines         = 256,
    parameter int unsigned TagLength        = 20,
    localparam int unsigned IdxW            = (NumLines > 1) ? $clog2(NumLines) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [SetAssociativity-1:0] ways_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [SetAssociativity-1:0] flushed_o,
    output logic                        req_valid_o,
    input  logic                        req_ready_i,
    output logic [IdxW-1:0]             req_index_o,
    output logic [SetAssociativity-1:0] req_indicator_o,
    input  logic                        res_valid_i,
    output logic                        res_ready_o,
    input  logic                        res_evict_i,
    input  logic [TagLength-1:0]        res_evict_tag_i,
    output logic                        evict_valid_o,
    input  logic                        evict_ready_i,
    output logic [TagLength-1:0]        evict_tag_o,
    output logic [IdxW-1:0]             evict_index_o,
    output logic [SetAssociativity-1:0] evict_way_o,
    output logic [31:0]                 evict_cnt_o
);

    localparam int unsigned W = SetAssociativity;

    typedef enum logic [2:0] {IDLE, REQ, RESP, EVICT, DONE} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      mask_q;
    logic [W-1:0]      way_q;
    logic [IdxW-1:0]   index_q;
    logic [W-1:0]      flushed_q;
    logic [TagLength-1:0] ev_tag_q;
    logic [IdxW-1:0]   ev_index_q;
    logic [W-1:0]      ev_way_q;

    logic              start_go;
    logic              last_line;
    logic              advance;
    logic [W-1:0]      above_mask;
    logic [W-1:0]      next_way;
    logic [W-1:0]      start_way;

    // Lowest set bit of the mask strictly above the current one-hot way.
    assign above_mask = mask_q & ~(way_q | (way_q - W'(1)));
    assign next_way   = above_mask & (~above_mask + W'(1));
    assign start_way  = ways_i & (~ways_i + W'(1));

    assign start_go  = (state_q == IDLE) && start_i;
    assign last_line = (index_q == IdxW'(NumLines - 1));
    assign advance   = ((state_q == RESP) && res_valid_i && !res_evict_i) ||
                       ((state_q == EVICT) && evict_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (ways_i != '0) ? REQ : DONE;
                end
            end
            REQ: begin
                if (req_ready_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (res_valid_i) begin
                    if (res_evict_i) begin
                        state_d = EVICT;
                    end else begin
                        state_d = (last_line && (next_way == '0)) ? DONE : REQ;
                    end
                end
            end
            EVICT: begin
                if (evict_ready_i) begin
                    state_d = (last_line && (next_way == '0)) ? DONE : REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q     <= '0;
            way_q      <= '0;
            index_q    <= '0;
            flushed_q  <= '0;
            ev_tag_q   <= '0;
            ev_index_q <= '0;
            ev_way_q   <= '0;
        end else begin
            if (start_go) begin
                mask_q    <= ways_i;
                way_q     <= start_way;
                index_q   <= '0;
                flushed_q <= '0;
            end
            if ((state_q == RESP) && res_valid_i && res_evict_i) begin
                ev_tag_q   <= res_evict_tag_i;
                ev_index_q <= index_q;
                ev_way_q   <= way_q;
            end
            // A way counts as flushed once its final line has fully retired.
            if (advance) begin
                if (last_line) begin
                    flushed_q <= flushed_q | way_q;
                    index_q   <= '0;
                    way_q     <= next_way;
                end else begin
                    index_q <= index_q + IdxW'(1);
                end
            end
        end
    end

`ifdef AXI_LLC_FLUSH_STATS_EN
    logic [31:0] evict_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evict_cnt_q <= '0;
        end else if (start_go) begin
            evict_cnt_q <= '0;
        end else if ((state_q == EVICT) && evict_ready_i && (evict_cnt_q != 32'hFFFF_FFFF)) begin
            evict_cnt_q <= evict_cnt_q + 32'd1;
        end
    end

    assign evict_cnt_o = evict_cnt_q;
`else
    assign evict_cnt_o = '0;
`endif

    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign flushed_o       = flushed_q;
    assign req_valid_o     = (state_q == REQ);
    assign req_index_o     = index_q;
    assign req_indicator_o = way_q;
    assign res_ready_o     = (state_q == RESP);
    assign evict_valid_o   = (state_q == EVICT);
    assign evict_tag_o     = ev_tag_q;
    assign evict_index_o   = ev_index_q;
    assign evict_way_o     = ev_way_q;

endmodule

// File: tb/tb_axi_llc_flush_walker.sv
// Randomised bench for axi_llc_flush_walker: a transaction-level model of the walk
// (expected line list, outstanding response, owed write-back) is checked every cycle.
module tb_axi_llc_flush_walker;

    localparam int W  = 4;
    localparam int NL = 8;
    localparam int T  = 20;
    localparam int IW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [W-1:0]  ways_i;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  flushed_o;
    logic          req_valid_o;
    logic          req_ready_i;
    logic [IW-1:0] req_index_o;
    logic [W-1:0]  req_indicator_o;
    logic          res_valid_i;
    logic          res_ready_o;
    logic          res_evict_i;
    logic [T-1:0]  res_evict_tag_i;
    logic          evict_valid_o;
    logic          evict_ready_i;
    logic [T-1:0]  evict_tag_o;
    logic [IW-1:0] evict_index_o;
    logic [W-1:0]  evict_way_o;
    logic [31:0]   evict_cnt_o;

    axi_llc_flush_walker #(
        .SetAssociativity(W),
        .NumLines(NL),
        .TagLength(T)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ways_i(ways_i),
        .busy_o(busy_o), .done_o(done_o), .flushed_o(flushed_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_index_o(req_index_o), .req_indicator_o(req_indicator_o),
        .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
        .res_evict_i(res_evict_i), .res_evict_tag_i(res_evict_tag_i),
        .evict_valid_o(evict_valid_o), .evict_ready_i(evict_ready_i),
        .evict_tag_o(evict_tag_o), .evict_index_o(evict_index_o),
        .evict_way_o(evict_way_o), .evict_cnt_o(evict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [W-1:0]  way;
        logic [IW-1:0] idx;
    } line_t;

    // Tag-store contents: which lines are dirty and their tags.
    bit           plan_ev [W][NL];
    logic [T-1:0] plan_tag[W][NL];

    // Environment knobs: 0 random, 1 tied high, 2 tied low.
    int rdy_mode, dly_mode, evr_mode;
    int stall_idx, stall_left;

    // Behavioural model state.
    bit            active, pending, owed;
    int            delay;
    line_t         expq[$];
    logic [W-1:0]  p_way, m_flushed;
    logic [IW-1:0] p_idx;
    logic [T-1:0]  ev_tag;
    int            m_cnt;
    logic [T-1:0]  last_tag;
    logic [IW-1:0] last_idx;
    logic [W-1:0]  last_way;
    int            busy_cnt, req_cnt, idx6_cnt;

    function automatic int oh2i(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef AXI_LLC_FLUSH_STATS_EN
        return 32'(m_cnt);
`else
        return 32'd0;
`endif
    endfunction

    function automatic void retire(input logic [W-1:0] way, input logic [IW-1:0] idx);
        if (int'(idx) == NL - 1) m_flushed = m_flushed | way;
    endfunction

    // Tag-store / write-back sink model plus the per-cycle compare.
    initial begin
        req_ready_i = 1'b0; res_valid_i = 1'b0; res_evict_i = 1'b0;
        res_evict_tag_i = '0; evict_ready_i = 1'b0;
        active = 0; pending = 0; owed = 0; delay = 0; m_flushed = '0; m_cnt = 0;
        p_way = '0; p_idx = '0; ev_tag = '0;
        forever begin
            bit rq, rs, ev;
            @(negedge clk_i);
            rq = req_valid_o && req_ready_i;
            rs = res_valid_i && res_ready_o;
            ev = evict_valid_o && evict_ready_i;
            if (rst_i) begin
                active = 0; pending = 0; owed = 0; expq.delete();
                m_flushed = '0; m_cnt = 0; rq = 0; rs = 0; ev = 0;
            end else begin
                chk("busy", 32'(busy_o), 32'(active));
                chk("req_valid", 32'(req_valid_o), 32'(active && !pending && !owed && expq.size() > 0));
                chk("res_ready", 32'(res_ready_o), 32'(pending));
                chk("evict_valid", 32'(evict_valid_o), 32'(owed));
                chk("done", 32'(done_o), 32'(active && !pending && !owed && expq.size() == 0));
                chk("flushed", 32'(flushed_o), 32'(m_flushed));
                chk("evict_cnt", evict_cnt_o, exp_cnt());
                if (busy_o) busy_cnt++;
                if (req_valid_o && req_index_o == 3'd6) idx6_cnt++;
                if (rq) begin
                    req_cnt++;
                    if (expq.size() > 0) begin
                        chk("req_way", 32'(req_indicator_o), 32'(expq[0].way));
                        chk("req_idx", 32'(req_index_o), 32'(expq[0].idx));
                        void'(expq.pop_front());
                    end
                    p_way = req_indicator_o;
                    p_idx = req_index_o;
                end
                if (rs) begin
                    if (res_evict_i) begin
                        owed = 1;
                        ev_tag = res_evict_tag_i;
                    end else begin
                        retire(p_way, p_idx);
                    end
                end
                if (ev) begin
                    chk("evict_tag", 32'(evict_tag_o), 32'(ev_tag));
                    chk("evict_idx", 32'(evict_index_o), 32'(p_idx));
                    chk("evict_way", 32'(evict_way_o), 32'(p_way));
                    last_tag = evict_tag_o; last_idx = evict_index_o; last_way = evict_way_o;
                    m_cnt++;
                    owed = 0;
                    retire(p_way, p_idx);
                end
                if (done_o && active && !pending && !owed && expq.size() == 0) active = 0;
                if (start_i && !active) begin
                    active = 1;
                    m_flushed = '0;
                    m_cnt = 0;
                    expq.delete();
                    for (int w = 0; w < W; w++)
                        if (ways_i[w])
                            for (int i = 0; i < NL; i++) expq.push_back(line_t'{W'(1 << w), IW'(i)});
                end
            end

            @(posedge clk_i);
            #1;
            if (rs) pending = 0;
            if (rq) begin
                pending = 1;
                delay = (dly_mode != 0) ? int'($urandom_range(0, 3)) : 0;
            end
            if (pending) begin
                if (delay > 0) begin
                    delay--;
                    res_valid_i = 1'b0;
                end else begin
                    res_valid_i = 1'b1;
                    res_evict_i = plan_ev[oh2i(p_way)][p_idx];
                    res_evict_tag_i = plan_tag[oh2i(p_way)][p_idx];
                end
            end else begin
                res_valid_i = 1'b0;
                res_evict_i = 1'($urandom_range(0, 1));
                res_evict_tag_i = T'($urandom);
            end
            req_ready_i = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            if (req_valid_o && int'(req_index_o) == stall_idx && stall_left > 0) begin
                req_ready_i = 1'b0;
                stall_left--;
            end
            evict_ready_i = (evr_mode == 1) ? 1'b1 : (evr_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    task automatic clear_plan();
        for (int w = 0; w < W; w++)
            for (int i = 0; i < NL; i++) begin
                plan_ev[w][i] = 1'b0;
                plan_tag[w][i] = T'($urandom);
            end
    endtask

    task automatic random_plan();
        for (int w = 0; w < W; w++)
            for (int i = 0; i < NL; i++) begin
                plan_ev[w][i] = ($urandom_range(0, 3) == 0);
                plan_tag[w][i] = T'($urandom);
            end
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i); #2;
            if (done_o) begin
                ok = 1;
                break;
            end
        end
        chk("done_within_budget", 32'(ok), 32'd1);
        if (!ok) do_reset();
    endtask

    task automatic start_walk(input logic [W-1:0] m);
        @(posedge clk_i); #1;
        busy_cnt = 0; req_cnt = 0;
        start_i = 1'b1;
        ways_i = m;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        ways_i = W'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit found;
        rst_i = 1'b1; start_i = 1'b0; ways_i = '0;
        rdy_mode = 1; dly_mode = 0; evr_mode = 1; stall_idx = 0; stall_left = 0;
        busy_cnt = 0; req_cnt = 0; idx6_cnt = 0;
        last_tag = '0; last_idx = '0; last_way = '0;
        clear_plan();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i); #2;
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_req_valid", 32'(req_valid_o), 32'd0);
        chk("reset_evict_valid", 32'(evict_valid_o), 32'd0);
        chk("reset_flushed", 32'(flushed_o), 32'd0);
        chk("reset_evict_cnt", evict_cnt_o, 32'd0);

        // Two ways, clean lines, everything ready: 2 cycles per line plus DONE.
        start_walk(4'b0101);
        wait_done(500);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd33);
        chk("t1_requests", 32'(req_cnt), 32'd16);
        chk("t1_flushed", 32'(flushed_o), 32'h5);

        // One dirty line in way 1 at index 3.
        clear_plan();
        plan_ev[1][3] = 1'b1;
        plan_tag[1][3] = 20'hABCDE;
        evr_mode = 0;
        start_walk(4'b0010);
        wait_done(500);
        chk("t2_evict_tag", 32'(last_tag), 32'hABCDE);
        chk("t2_evict_idx", 32'(last_idx), 32'd3);
        chk("t2_evict_way", 32'(last_way), 32'h2);
        chk("t2_requests", 32'(req_cnt), 32'd8);
`ifdef AXI_LLC_FLUSH_STATS_EN
        chk("t2_evict_cnt", evict_cnt_o, 32'd1);
`else
        chk("t2_evict_cnt", evict_cnt_o, 32'd0);
`endif

        // Request back-pressure at index 6.
        clear_plan();
        evr_mode = 1;
        stall_idx = 6; stall_left = 5; idx6_cnt = 0;
        start_walk(4'b0001);
        wait_done(500);
        chk("t3_idx6_valid_cycles", 32'(idx6_cnt), 32'd6);
        chk("t3_requests", 32'(req_cnt), 32'd8);
        stall_left = 0;

        // Empty mask goes straight to a single done pulse.
        @(posedge clk_i); #1;
        req_cnt = 0;
        start_i = 1'b1; ways_i = 4'b0000;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i); #2;
        chk("t4_done", 32'(done_o), 32'd1);
        chk("t4_flushed", 32'(flushed_o), 32'd0);
        @(negedge clk_i); #2;
        chk("t4_done_pulse", 32'(done_o), 32'd0);
        chk("t4_requests", 32'(req_cnt), 32'd0);

        // Reset while a write-back of way 1 index 5 is stalled.
        clear_plan();
        plan_ev[1][5] = 1'b1;
        evr_mode = 2;
        start_walk(4'b0010);
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i); #2;
            if (evict_valid_o && evict_index_o == 3'd5 && evict_way_o == 4'b0010) begin
                found = 1;
                break;
            end
        end
        chk("t5_evict_reached", 32'(found), 32'd1);
        do_reset();
        @(negedge clk_i); #2;
        chk("t5_busy", 32'(busy_o), 32'd0);
        chk("t5_evict_valid", 32'(evict_valid_o), 32'd0);
        chk("t5_req_valid", 32'(req_valid_o), 32'd0);
        chk("t5_flushed", 32'(flushed_o), 32'd0);
        evr_mode = 1;
        clear_plan();
        start_walk(4'b0010);
        wait_done(500);
        chk("t5_rewalk_requests", 32'(req_cnt), 32'd8);
        chk("t5_rewalk_flushed", 32'(flushed_o), 32'h2);

        // Start while busy is ignored.
        random_plan();
        rdy_mode = 0; dly_mode = 1; evr_mode = 0;
        start_walk(4'b0110);
        repeat (3) @(posedge clk_i);
        #1 start_i = 1'b1; ways_i = 4'b1111;
        @(posedge clk_i); #1 start_i = 1'b0;
        wait_done(2000);
        chk("t6_requests", 32'(req_cnt), 32'd16);
        chk("t6_flushed", 32'(flushed_o), 32'h6);

        // Randomised walks.
        for (int n = 0; n < 12; n++) begin
            logic [W-1:0] m;
            m = W'($urandom);
            random_plan();
            rdy_mode = int'($urandom_range(0, 1));
            dly_mode = int'($urandom_range(0, 1));
            evr_mode = int'($urandom_range(0, 1));
            start_walk(m);
            wait_done(3000);
            chk("rand_flushed", 32'(flushed_o), 32'(m));
            chk("rand_requests", 32'(req_cnt), 32'($countones(m) * NL));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
